// File: rtl/fastfir_dualbank_if.sv
// Bus bundle for fastfir_dualbank: tap load/swap controls, sample stream in, result stream out.
interface fastfir_dualbank_if #(
    parameter int unsigned IW = 12,
    parameter int unsigned TW = IW,
    parameter int unsigned OW = 2 * IW + 7
);
    logic                 i_tap_wr;
    logic signed [TW-1:0] i_tap;
    logic                 i_tap_swap;
    logic                 i_ce;
    logic signed [IW-1:0] i_sample;
    logic                 o_tap_full;
    logic                 o_bank;
    logic                 o_ce;
    logic signed [OW-1:0] o_result;

    modport master (
        output i_tap_wr, i_tap, i_tap_swap, i_ce, i_sample,
        input  o_tap_full, o_bank, o_ce, o_result
    );

    modport slave (
        input  i_tap_wr, i_tap, i_tap_swap, i_ce, i_sample,
        output o_tap_full, o_bank, o_ce, o_result
    );
endinterface

// File: rtl/fastfir_dualbank.sv
// Fully parallel dynamic-tap FIR with shadow/active coefficient banks swapped on a sample boundary.
module fastfir_dualbank #(
    parameter int unsigned NTAPS = 16,
    parameter int unsigned IW    = 12,
    parameter int unsigned TW    = IW,
    parameter int unsigned OW    = 2 * IW + 7
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    fastfir_dualbank_if.slave bus
);
    localparam int unsigned PW  = IW + TW;
    localparam int unsigned WIW = $clog2(NTAPS);

    if (NTAPS < 2) begin : g_bad_ntaps
        $error("fastfir_dualbank: NTAPS must be >= 2");
    end
    if (OW < IW + TW + $clog2(NTAPS)) begin : g_bad_ow
        $error("fastfir_dualbank: OW too narrow for full-precision sum");
    end

    logic signed [TW-1:0] taps   [2][NTAPS];
    logic signed [IW-1:0] sr     [NTAPS-1];
    logic signed [PW-1:0] prod   [NTAPS];
    logic signed [PW-1:0] prod_c [NTAPS];
    logic signed [IW-1:0] x_c    [NTAPS];
    logic signed [OW-1:0] sum_c;
    logic signed [OW-1:0] result;
    logic [WIW-1:0]       widx;
    logic                 tap_full;
    logic                 bank;
    logic                 ce_d;
    logic                 ce_q;
    logic                 swap_ok_c;

    // A swap is only honoured once the shadow bank has been completely rewritten.
    assign swap_ok_c = bus.i_tap_swap & tap_full;

    // Products use the bank that was active before the edge, so a coincident swap is sample-atomic.
    always_comb begin
        x_c[0] = bus.i_sample;
        for (int unsigned k = 1; k < NTAPS; k++) begin
            x_c[k] = sr[k-1];
        end
        for (int unsigned k = 0; k < NTAPS; k++) begin
            prod_c[k] = PW'(taps[bank][k]) * PW'(x_c[k]);
        end
    end

    always_comb begin
        sum_c = '0;
        for (int unsigned k = 0; k < NTAPS; k++) begin
            sum_c = sum_c + OW'(prod[k]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned k = 0; k < NTAPS; k++) begin
                    taps[b][k] <= '0;
                end
            end
            for (int unsigned k = 0; k < NTAPS - 1; k++) begin
                sr[k] <= '0;
            end
            for (int unsigned k = 0; k < NTAPS; k++) begin
                prod[k] <= '0;
            end
            widx     <= '0;
            tap_full <= 1'b0;
            bank     <= 1'b0;
            ce_d     <= 1'b0;
            ce_q     <= 1'b0;
            result   <= '0;
        end else begin
            // Writes target the pre-edge shadow even when a swap is accepted on the same edge.
            if (bus.i_tap_wr) begin
                taps[~bank][widx] <= bus.i_tap;
            end

            if (swap_ok_c) begin
                bank     <= ~bank;
                widx     <= '0;
                tap_full <= 1'b0;
            end else if (bus.i_tap_wr) begin
                if (widx == WIW'(NTAPS - 1)) begin
                    widx     <= '0;
                    tap_full <= 1'b1;
                end else begin
                    widx <= widx + WIW'(1);
                end
            end

            ce_d <= bus.i_ce;
            if (bus.i_ce) begin
                sr[0] <= bus.i_sample;
                for (int unsigned k = 1; k < NTAPS - 1; k++) begin
                    sr[k] <= sr[k-1];
                end
                prod <= prod_c;
            end

            ce_q <= ce_d;
            if (ce_d) begin
                result <= sum_c;
            end
        end
    end

    assign bus.o_tap_full = tap_full;
    assign bus.o_bank     = bank;
    assign bus.o_ce       = ce_q;
    assign bus.o_result   = result;
endmodule

// File: tb/tb_fastfir_dualbank.sv
// Directed bench for fastfir_dualbank with a reference model and result scoreboard.
module tb_fastfir_dualbank;
    localparam int unsigned NTAPS = 16;
    localparam int unsigned IW    = 12;
    localparam int unsigned TW    = 12;
    localparam int unsigned OW    = 31;
    localparam logic signed [TW-1:0] TMIN = {1'b1, {(TW-1){1'b0}}};
    localparam logic signed [IW-1:0] SMIN = {1'b1, {(IW-1){1'b0}}};

    typedef struct {
        int     due;
        longint val;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   vectors;
    int   errors;
    exp_t q[$];
    exp_t mon_e;
    logic mon_ce;

    // Reference model state
    logic signed [TW-1:0] m_taps [2][NTAPS];
    logic signed [IW-1:0] m_sr   [NTAPS];
    logic                 m_bank;
    logic                 m_full;
    int                   m_widx;

    fastfir_dualbank_if #(.IW(IW), .TW(TW), .OW(OW)) bus ();

    fastfir_dualbank #(.NTAPS(NTAPS), .IW(IW), .TW(TW), .OW(OW)) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, expv, cyc);
        end
    endtask

    task automatic model_clear();
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < NTAPS; k++) m_taps[b][k] = '0;
        for (int k = 0; k < NTAPS; k++) m_sr[k] = '0;
        m_bank = 1'b0;
        m_full = 1'b0;
        m_widx = 0;
        q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        model_clear();
        #1;
        rst_n = 1'b1;
    endtask

    // One clock of stimulus; expected result is computed from pre-edge model state.
    task automatic step(input logic wr, input logic signed [TW-1:0] tap, input logic swap,
                        input logic ce, input logic signed [IW-1:0] smp);
        longint acc;
        int     due;
        bus.i_tap_wr   = wr;
        bus.i_tap      = tap;
        bus.i_tap_swap = swap;
        bus.i_ce       = ce;
        bus.i_sample   = smp;
        due = cyc + 2;
        acc = 0;
        if (ce) begin
            acc = longint'(m_taps[m_bank][0]) * longint'(smp);
            for (int k = 1; k < NTAPS; k++)
                acc += longint'(m_taps[m_bank][k]) * longint'(m_sr[k-1]);
        end
        @(posedge clk);
        if (ce) begin
            q.push_back('{due: due, val: acc});
            for (int k = NTAPS - 1; k > 0; k--) m_sr[k] = m_sr[k-1];
            m_sr[0] = smp;
        end
        if (wr) m_taps[~m_bank][m_widx] = tap;
        if (swap && m_full) begin
            m_bank = ~m_bank;
            m_widx = 0;
            m_full = 1'b0;
        end else if (wr) begin
            if (m_widx == NTAPS - 1) m_full = 1'b1;
            m_widx = (m_widx + 1) % NTAPS;
        end
        #1;
        bus.i_tap_wr   = 1'b0;
        bus.i_tap_swap = 1'b0;
        bus.i_ce       = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic impulse();
        step(1'b0, '0, 1'b0, 1'b1, IW'(1));
        for (int i = 0; i < NTAPS; i++) step(1'b0, '0, 1'b0, 1'b1, '0);
        idle(3);
    endtask

    // Per-cycle monitor: strobe timing, result scoreboard, and bank status.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_ce = (q.size() > 0) && (q[0].due == cyc);
            chk("o_ce", 64'(bus.o_ce), 64'(mon_ce));
            if (mon_ce) begin
                mon_e = q.pop_front();
                chk("o_result", 64'($unsigned(bus.o_result)), 64'($unsigned(OW'(mon_e.val))));
            end
            chk("o_tap_full", 64'(bus.o_tap_full), 64'(m_full));
            chk("o_bank", 64'(bus.o_bank), 64'(m_bank));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0;
        errors  = 0;
        bus.i_tap_wr = 1'b0; bus.i_tap = '0; bus.i_tap_swap = 1'b0;
        bus.i_ce = 1'b0; bus.i_sample = '0;
        model_clear();

        // 1: reset state, taps 1..16, swap, impulse response
        do_reset();
        chk("rst_result", 64'($unsigned(bus.o_result)), 64'd0);
        chk("rst_ce", 64'(bus.o_ce), 64'd0);
        for (int k = 0; k < NTAPS; k++) step(1'b1, TW'(k + 1), 1'b0, 1'b0, '0);
        chk("t1_full", 64'(bus.o_tap_full), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0, '0);
        chk("t1_bank", 64'(bus.o_bank), 64'd1);
        impulse();

        // 2: partial load, refused swap, refused swap with write, zero outputs
        do_reset();
        for (int k = 0; k < NTAPS - 1; k++) step(1'b1, TW'(k + 3), 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b1, 1'b0, '0);
        chk("t2_bank", 64'(bus.o_bank), 64'd0);
        chk("t2_full", 64'(bus.o_tap_full), 64'd0);
        step(1'b1, TW'(77), 1'b1, 1'b0, '0);
        chk("t2_full_after_wr", 64'(bus.o_tap_full), 64'd1);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b1, IW'($urandom_range(0, 4095)));
        idle(3);
        chk("t2_zero", 64'($unsigned(bus.o_result)), 64'd0);

        // 3: swap coincident with a sample keeps old taps for that sample
        do_reset();
        for (int k = 0; k < NTAPS; k++) step(1'b1, TW'(1), 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b1, 1'b0, '0);
        for (int k = 0; k < NTAPS; k++) step(1'b1, TW'(2), 1'b0, 1'b0, '0);
        for (int i = 0; i < 18; i++) step(1'b0, '0, 1'b0, 1'b1, IW'(1));
        step(1'b0, '0, 1'b1, 1'b1, IW'(1));
        idle(1);
        chk("t3_old_bank", 64'($unsigned(bus.o_result)), 64'd16);
        step(1'b0, '0, 1'b0, 1'b1, IW'(1));
        idle(1);
        chk("t3_new_bank", 64'($unsigned(bus.o_result)), 64'd32);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1, IW'(1));
        idle(3);

        // 4: most-negative taps times most-negative samples
        do_reset();
        for (int k = 0; k < NTAPS; k++) step(1'b1, TMIN, 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b1, 1'b0, '0);
        for (int i = 0; i < NTAPS; i++) step(1'b0, '0, 1'b0, 1'b1, SMIN);
        idle(3);
        chk("t4_max", 64'($unsigned(bus.o_result)), 64'd67108864);
        chk("t4_sign", 64'(bus.o_result[OW-1]), 64'd0);

        // 5: reset mid-load restarts the write index
        do_reset();
        for (int k = 0; k < 8; k++) step(1'b1, TW'(9), 1'b0, 1'b0, '0);
        do_reset();
        chk("t5_full", 64'(bus.o_tap_full), 64'd0);
        for (int k = 0; k < NTAPS - 1; k++) step(1'b1, TW'(k - 5), 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b1, 1'b0, '0);
        chk("t5_refused", 64'(bus.o_bank), 64'd0);
        step(1'b1, TW'(-7), 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b1, 1'b0, '0);
        chk("t5_accepted", 64'(bus.o_bank), 64'd1);
        impulse();

        // 6: wrapped writes, then write+swap on the same edge lands in the new active bank
        do_reset();
        for (int k = 0; k < 20; k++) step(1'b1, TW'(k), 1'b0, 1'b0, '0);
        chk("t6_full", 64'(bus.o_tap_full), 64'd1);
        step(1'b1, TW'(100), 1'b1, 1'b0, '0);
        chk("t6_bank", 64'(bus.o_bank), 64'd1);
        chk("t6_full_clr", 64'(bus.o_tap_full), 64'd0);
        impulse();

        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
